position_control: RTL and testbench

POSITION_CONTROL -- requirements
Module: position_control

---
 rtl/position_control_if.sv | 31 +++
 rtl/position_control.sv | 125 ++++++++++++
 tb/tb_position_control.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/position_control_if.sv
// position_control_if -- bundle between the position controller (slave side)
// and its environment: direction keys, legality checker handshake, and the
// committed/candidate position outputs.
interface position_control_if;
    logic       keyLeft, keyRight, keyUp, keyDown;
    logic       doneCheckLegal, isLegal;
    logic       gameWon, gameOver;
    logic [4:0] x, y;
    logic       moveLeft, moveRight, moveUp, moveDown;
    logic       doneChangePosition;
    logic [4:0] currentX, currentY;
    logic [7:0] movesUsed;
    logic       noMoreMoves;
    logic       positionUpdated;

    modport slave (
        input  keyLeft, keyRight, keyUp, keyDown,
        input  doneCheckLegal, isLegal, gameWon, gameOver,
        output x, y, moveLeft, moveRight, moveUp, moveDown,
        output doneChangePosition, currentX, currentY,
        output movesUsed, noMoreMoves, positionUpdated
    );

    modport master (
        output keyLeft, keyRight, keyUp, keyDown,
        output doneCheckLegal, isLegal, gameWon, gameOver,
        input  x, y, moveLeft, moveRight, moveUp, moveDown,
        input  doneChangePosition, currentX, currentY,
        input  movesUsed, noMoreMoves, positionUpdated
    );
endinterface

// File: rtl/position_control.sv
// position_control -- turns one key press into one candidate move, asks the
// legality checker about it, and commits or reverts the player position.
// Optional feature: define POSITION_MOVE_LIMIT_EN to count accepted moves and
// stop accepting keys once MAX_MOVES is reached; otherwise movesUsed stays 0.
module position_control #(
    parameter logic [4:0] START_X   = 5'd1,
    parameter logic [4:0] START_Y   = 5'd1,
    parameter logic [4:0] MAX_COORD = 5'd23,
    parameter logic [7:0] MAX_MOVES = 8'd200,
    parameter logic [3:0] WATCHDOG  = 4'd15
) (
    input  logic               clock,
    input  logic               resetn,
    position_control_if.slave  bus
);
`ifdef POSITION_MOVE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, CALC, REQUEST, WAIT_LEGAL, COMMIT, REVERT, WAIT_RELEASE, HALT
    } state_t;

    state_t     state;
    logic [4:0] xReg, yReg, curX, curY;
    logic [3:0] dir;          // {down, up, right, left}, one-hot or zero
    logic       strobe, updated;
    logic [7:0] moves;
    logic [3:0] wdCnt;
    logic       anyKey, stop, budgetOut;

    assign anyKey    = bus.keyLeft | bus.keyRight | bus.keyUp | bus.keyDown;
    assign stop      = bus.gameWon | bus.gameOver;
    assign budgetOut = LIMIT_EN && (moves >= MAX_MOVES);

    assign bus.x                  = xReg;
    assign bus.y                  = yReg;
    assign bus.moveLeft           = dir[0];
    assign bus.moveRight          = dir[1];
    assign bus.moveUp             = dir[2];
    assign bus.moveDown           = dir[3];
    assign bus.doneChangePosition = strobe;
    assign bus.currentX           = curX;
    assign bus.currentY           = curY;
    assign bus.movesUsed          = moves;
    assign bus.noMoreMoves        = budgetOut;
    assign bus.positionUpdated    = updated;

    // Move sequencer: commit/revert happen on the edge leaving WAIT_LEGAL so
    // that x/y track currentX/Y and flags are clear everywhere else.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            xReg    <= START_X;
            yReg    <= START_Y;
            curX    <= START_X;
            curY    <= START_Y;
            dir     <= 4'b0000;
            strobe  <= 1'b0;
            updated <= 1'b0;
            moves   <= 8'd0;
            wdCnt   <= 4'd0;
        end else begin
            strobe  <= 1'b0;
            updated <= 1'b0;
            if (state != HALT && stop) begin
                // Abandon any pending candidate; a commit already happened on
                // entry to COMMIT, so halting from there keeps it.
                state <= HALT;
                xReg  <= curX;
                yReg  <= curY;
                dir   <= 4'b0000;
            end else begin
                case (state)
                    IDLE: begin
                        if (anyKey && !budgetOut) begin
                            if (bus.keyLeft)       dir <= 4'b0001;
                            else if (bus.keyRight) dir <= 4'b0010;
                            else if (bus.keyUp)    dir <= 4'b0100;
                            else                   dir <= 4'b1000;
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        // Edges clamp; the flag stays set so the checker rejects.
                        if (dir[0] && curX != 5'd0)      xReg <= curX - 5'd1;
                        if (dir[1] && curX <  MAX_COORD) xReg <= curX + 5'd1;
                        if (dir[2] && curY != 5'd0)      yReg <= curY - 5'd1;
                        if (dir[3] && curY <  MAX_COORD) yReg <= curY + 5'd1;
                        strobe <= 1'b1;
                        state  <= REQUEST;
                    end
                    REQUEST: begin
                        wdCnt <= 4'd0;
                        state <= WAIT_LEGAL;
                    end
                    WAIT_LEGAL: begin
                        if (bus.doneCheckLegal && bus.isLegal) begin
                            curX    <= xReg;
                            curY    <= yReg;
                            updated <= 1'b1;
                            dir     <= 4'b0000;
                            if (LIMIT_EN && moves != 8'hFF) moves <= moves + 8'd1;
                            state   <= COMMIT;
                        end else if (bus.doneCheckLegal || wdCnt == WATCHDOG - 4'd1) begin
                            xReg  <= curX;
                            yReg  <= curY;
                            dir   <= 4'b0000;
                            state <= REVERT;
                        end else begin
                            wdCnt <= wdCnt + 4'd1;
                        end
                    end
                    COMMIT:       state <= WAIT_RELEASE;
                    REVERT:       state <= WAIT_RELEASE;
                    WAIT_RELEASE: if (!anyKey) state <= IDLE;
                    HALT:         state <= HALT;
                    default:      state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_position_control.sv
// tb_position_control -- randomized and directed checks of position_control
// against a position/budget model kept in the bench.
module tb_position_control;
    localparam logic [7:0] MAXM = 8'd3;
    localparam int         WD   = 15;
`ifdef POSITION_MOVE_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    position_control_if bus();

    position_control #(.MAX_MOVES(MAXM)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int nChecks = 0, nFail = 0;
    int strobeCnt = 0, updCnt = 0;
    logic [4:0] mX, mY;
    int mMoves;

    // Pulse counters sampled away from the active edge
    always @(negedge clock) begin
        if (bus.doneChangePosition) strobeCnt++;
        if (bus.positionUpdated) updCnt++;
    end

    function automatic logic [3:0] flags();
        return {bus.moveDown, bus.moveUp, bus.moveRight, bus.moveLeft};
    endfunction

    task automatic setKeys(input logic [3:0] k);
        {bus.keyDown, bus.keyUp, bus.keyRight, bus.keyLeft} = k;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        setKeys(4'b0000);
        bus.doneCheckLegal = 0; bus.isLegal = 0; bus.gameWon = 0; bus.gameOver = 0;
        mX = 5'd1; mY = 5'd1; mMoves = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // One key press; resp: 0 = checker silent, 1 = legal, 2 = illegal
    task automatic move(input logic [3:0] keys, input int resp, input int dly);
        logic [3:0] edir;
        logic [4:0] ex, ey;
        bit blocked, seen;
        int s0, u0, bad;
        blocked = LIM && (mMoves >= int'(MAXM));
        edir = keys[0] ? 4'b0001 : keys[1] ? 4'b0010 : keys[2] ? 4'b0100 : keys[3] ? 4'b1000 : 4'b0000;
        ex = mX; ey = mY;
        if (edir == 4'b0001 && ex > 0)  ex = ex - 1;
        if (edir == 4'b0010 && ex < 23) ex = ex + 1;
        if (edir == 4'b0100 && ey > 0)  ey = ey - 1;
        if (edir == 4'b1000 && ey < 23) ey = ey + 1;
        s0 = strobeCnt; u0 = updCnt; seen = 0; bad = 0;
        setKeys(keys);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (bus.doneChangePosition) seen = 1;
        end
        nChecks++;
        if (seen !== (!blocked && edir != 0)) begin
            nFail++; $display("FAIL strobe_issued: got %0d want %0d", seen, !blocked && edir != 0);
        end
        if (seen) begin
            nChecks++;
            if (bus.x !== ex || bus.y !== ey || flags() !== edir) begin
                nFail++;
                $display("FAIL candidate: got x=%0d y=%0d dir=%b want x=%0d y=%0d dir=%b",
                         bus.x, bus.y, flags(), ex, ey, edir);
            end
            if (resp != 0) begin
                repeat (dly) begin
                    @(negedge clock);
                    if (bus.x !== ex || bus.y !== ey || flags() !== edir) bad++;
                end
                bus.doneCheckLegal = 1; bus.isLegal = (resp == 1);
                @(negedge clock);
                bus.doneCheckLegal = 0; bus.isLegal = 0;
                nChecks++;
                if (bad != 0) begin
                    nFail++; $display("FAIL candidate_stable: %0d unstable cycles, want 0", bad);
                end
                if (resp == 1) begin
                    mX = ex; mY = ey;
                    if (LIM && mMoves < 255) mMoves++;
                end
            end else begin
                repeat (WD + 2) @(negedge clock);
            end
        end
        setKeys(4'b0000);
        repeat (4) @(negedge clock);
        nChecks++;
        if (bus.currentX !== mX || bus.currentY !== mY || bus.x !== mX || bus.y !== mY || flags() !== 4'b0) begin
            nFail++;
            $display("FAIL position: got cur=(%0d,%0d) xy=(%0d,%0d) dir=%b want (%0d,%0d) dir=0",
                     bus.currentX, bus.currentY, bus.x, bus.y, flags(), mX, mY);
        end
        nChecks++;
        if (bus.movesUsed !== 8'(LIM ? mMoves : 0) || bus.noMoreMoves !== (LIM && mMoves >= int'(MAXM))) begin
            nFail++;
            $display("FAIL budget: got moves=%0d nmm=%b want moves=%0d nmm=%b",
                     bus.movesUsed, bus.noMoreMoves, LIM ? mMoves : 0, LIM && mMoves >= int'(MAXM));
        end
        nChecks++;
        if (strobeCnt - s0 !== int'(seen) || updCnt - u0 !== int'(seen && resp == 1)) begin
            nFail++;
            $display("FAIL pulse_count: got strobes=%0d updates=%0d want %0d %0d",
                     strobeCnt - s0, updCnt - u0, seen, seen && resp == 1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        move(4'b0010, 1, 2);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        nChecks++;
        if (bus.x !== 5'd1 || bus.y !== 5'd1 || bus.currentX !== 5'd1 || bus.currentY !== 5'd1 ||
            bus.movesUsed !== 8'd0 || flags() !== 4'b0 || bus.doneChangePosition !== 1'b0 ||
            bus.positionUpdated !== 1'b0 || bus.noMoreMoves !== 1'b0) begin
            nFail++;
            $display("FAIL reset_values: got xy=(%0d,%0d) cur=(%0d,%0d) moves=%0d dir=%b want (1,1) (1,1) 0 0",
                     bus.x, bus.y, bus.currentX, bus.currentY, bus.movesUsed, flags());
        end
        @(negedge clock);
        resetn = 1'b1;
        mX = 5'd1; mY = 5'd1; mMoves = 0;
        @(negedge clock);
    endtask

    task automatic test_single_right();
        do_reset();
        move(4'b0010, 1, 3);
        nChecks++;
        if (bus.currentX !== 5'd2) begin
            nFail++; $display("FAIL single_right: got currentX=%0d want 2", bus.currentX);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        move(4'b0001, 1, 1);   // x 1 -> 0
        move(4'b0001, 2, 6);   // clamped at 0, rejected
        move(4'b0100, 1, 2);   // y 1 -> 0
        move(4'b0100, 2, 4);   // clamped at 0, rejected
    endtask

    task automatic test_two_keys();
        int s0;
        bit seen;
        do_reset();
        s0 = strobeCnt; seen = 0;
        setKeys(4'b1001);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.doneChangePosition && !seen) begin
                seen = 1;
                nChecks++;
                if (bus.moveLeft !== 1'b1 || bus.moveDown !== 1'b0 || bus.x !== 5'd0 || bus.y !== 5'd1) begin
                    nFail++; $display("FAIL two_keys_dir: got dir=%b x=%0d y=%0d want 0001 0 1", flags(), bus.x, bus.y);
                end
            end
            bus.doneCheckLegal = seen && bus.moveLeft;
            bus.isLegal = bus.doneCheckLegal;
        end
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        nChecks++;
        if (strobeCnt - s0 !== 1) begin
            nFail++; $display("FAIL two_keys_once: got %0d requests want 1", strobeCnt - s0);
        end
        mX = 5'd0; if (LIM) mMoves = 1;
        setKeys(4'b0000);
        repeat (2) @(negedge clock);
        move(4'b0010, 1, 2);
    endtask

    task automatic test_watchdog();
        int hi;
        bit seen;
        do_reset();
        setKeys(4'b0100);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (bus.doneChangePosition) seen = 1;
        end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.moveUp) hi++;
        end
        nChecks++;
        if (!seen || hi !== WD) begin
            nFail++; $display("FAIL watchdog_wait: got seen=%0d wait=%0d want 1 %0d", seen, hi, WD);
        end
        nChecks++;
        if (bus.x !== 5'd1 || bus.y !== 5'd1 || bus.currentY !== 5'd1) begin
            nFail++; $display("FAIL watchdog_restore: got (%0d,%0d) want (1,1)", bus.x, bus.y);
        end
        setKeys(4'b0000);
        repeat (2) @(negedge clock);
        move(4'b0010, 1, 5);
    endtask

    task automatic test_halt();
        int s0;
        do_reset();
        setKeys(4'b0010);
        for (int i = 0; i < 10 && !bus.doneChangePosition; i++) @(negedge clock);
        @(negedge clock);
        bus.gameWon = 1;
        @(negedge clock);
        bus.gameWon = 0;
        bus.doneCheckLegal = 1; bus.isLegal = 1;
        @(negedge clock);
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        setKeys(4'b0000);
        @(negedge clock);
        s0 = strobeCnt;
        for (int i = 0; i < 30; i++) begin
            setKeys(4'($urandom_range(0, 15)));
            @(negedge clock);
        end
        setKeys(4'b0000);
        @(negedge clock);
        nChecks++;
        if (strobeCnt !== s0 || bus.currentX !== 5'd1 || bus.x !== 5'd1 || flags() !== 4'b0) begin
            nFail++;
            $display("FAIL halt: got strobes=%0d cur=%0d x=%0d dir=%b want 0 1 1 0",
                     strobeCnt - s0, bus.currentX, bus.x, flags());
        end
        do_reset();
        nChecks++;
        if (bus.currentX !== 5'd1 || bus.currentY !== 5'd1) begin
            nFail++; $display("FAIL halt_reset: got (%0d,%0d) want (1,1)", bus.currentX, bus.currentY);
        end
        move(4'b1000, 1, 2);
        // gameOver from IDLE also freezes
        bus.gameOver = 1;
        @(negedge clock);
        bus.gameOver = 0;
        s0 = strobeCnt;
        setKeys(4'b0010);
        repeat (10) @(negedge clock);
        setKeys(4'b0000);
        @(negedge clock);
        nChecks++;
        if (strobeCnt !== s0) begin
            nFail++; $display("FAIL halt_gameover: got %0d requests want 0", strobeCnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0, u0;
        do_reset();
        s0 = strobeCnt; u0 = updCnt;
        setKeys(4'b1000);
        for (int i = 0; i < 10 && !bus.doneChangePosition; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        bus.doneCheckLegal = 1; bus.isLegal = 1;
        setKeys(4'b0000);
        @(negedge clock);
        bus.doneCheckLegal = 0; bus.isLegal = 0;
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        nChecks++;
        if (strobeCnt - s0 !== 1 || updCnt !== u0 || bus.currentY !== 5'd1 || bus.y !== 5'd1) begin
            nFail++;
            $display("FAIL reset_mid: got strobes=%0d updates=%0d y=%0d want 1 0 1",
                     strobeCnt - s0, updCnt - u0, bus.currentY);
        end
        mX = 5'd1; mY = 5'd1; mMoves = 0;
    endtask

    task automatic test_budget();
        do_reset();
        move(4'b0010, 1, 1);
        move(4'b0010, 1, 2);
        move(4'b1000, 1, 3);
        move(4'b0010, 1, 2);   // blocked only with the move limit enabled
    endtask

    task automatic test_random();
        logic [3:0] k;
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int t = 0; t < 6; t++) begin
                k = 4'($urandom_range(1, 15));
                move(k, int'($urandom_range(0, 2)), int'($urandom_range(1, 12)));
            end
        end
    endtask

    initial begin
        setKeys(4'b0000);
        bus.doneCheckLegal = 0; bus.isLegal = 0; bus.gameWon = 0; bus.gameOver = 0;
        test_reset();
        test_single_right();
        test_boundary();
        test_two_keys();
        test_watchdog();
        test_halt();
        test_reset_mid();
        test_budget();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
